sequenced_executor: RTL

Parametrised multi-cycle instruction executor that drives a register-file memory over a shared tri-state data bus. It accepts one 4-bit-opcode instruction per Start/Done handshake and performs the needed register reads, arithmetic and register writes. Over the earlier executor it adds the full ALU opcode set (add, sub, shift, multiply, divide), a binary register address bus, busy/error/flag outputs, and parametrised data and address widths. It sits between the instruction sequencer and the register memory.

---
 rtl/sequenced_executor.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sequenced_executor.sv
// rtl/sequenced_executor.sv - multi-cycle ALU instruction executor over a shared register-file bus
module sequenced_executor #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [4+2*N-1:0] OpCode,
    output logic [M-1:0]     MemorySelect,
    inout  wire  [N-1:0]     MemoryData,
    output logic             MemoryRW,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic             Zero,
    output logic             Carry
);

    localparam logic [3:0] OP_LDC   = 4'h1;
    localparam logic [3:0] OP_LDR   = 4'h2;
    localparam logic [3:0] OP_ADD_C = 4'h3;
    localparam logic [3:0] OP_ADD_R = 4'h4;
    localparam logic [3:0] OP_SUB_C = 4'h5;
    localparam logic [3:0] OP_SUB_R = 4'h6;
    localparam logic [3:0] OP_MUL_C = 4'h7;
    localparam logic [3:0] OP_MUL_R = 4'h8;
    localparam logic [3:0] OP_DIV_C = 4'h9;
    localparam logic [3:0] OP_DIV_R = 4'hA;
    localparam logic [3:0] OP_SHL_C = 4'hB;
    localparam logic [3:0] OP_SHR_C = 4'hC;
    localparam logic [3:0] OP_SHL_R = 4'hD;
    localparam logic [3:0] OP_SHR_R = 4'hE;

    localparam int             CW          = $clog2(N) + 1;
    localparam logic [CW-1:0]  CNT_LAST    = CW'(N - 1);
    localparam logic [N-1:0]   SHIFT_LIMIT = N[N-1:0];
    localparam logic [M-1:0]   ADDR_RA     = '0;
    localparam logic [M-1:0]   ADDR_RD     = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ_A, S_READ_B, S_EXEC, S_WRITE_LO, S_WRITE_HI, S_FINISH
    } state_t;

    state_t          state;
    logic [3:0]      op;
    logic [M-1:0]    r1, r2;
    logic [N-1:0]    a, b;
    logic [N-1:0]    wdata, res_lo, res_hi;
    logic            res_c;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    div_rem, div_q;

    logic [3:0]      op_in;
    logic [N-1:0]    p1, p2;
    logic            unused_p1_high;

    assign op_in          = OpCode[4+2*N-1 -: 4];
    assign p1             = OpCode[2*N-1:N];
    assign p2             = OpCode[N-1:0];
    assign unused_p1_high = ^p1;

    assign MemoryData = MemoryRW ? wdata : {N{1'bz}};

    function automatic logic is_reg_op(input logic [3:0] o);
        return (o == OP_ADD_R) || (o == OP_SUB_R) || (o == OP_MUL_R) ||
               (o == OP_DIV_R) || (o == OP_SHL_R) || (o == OP_SHR_R);
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return (o == OP_DIV_C) || (o == OP_DIV_R);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] o);
        return (o == OP_MUL_C) || (o == OP_MUL_R);
    endfunction

    logic [N-1:0]   alu_lo, alu_hi;
    logic           alu_c;
    logic [N:0]     sum;
    logic [2*N-1:0] prod;

    // Single-cycle ALU result for every non-divide operation
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        alu_c  = 1'b0;
        sum    = '0;
        prod   = '0;
        case (op)
            OP_ADD_C, OP_ADD_R: begin
                sum    = {1'b0, a} + {1'b0, b};
                alu_lo = sum[N-1:0];
                alu_c  = sum[N];
            end
            OP_SUB_C, OP_SUB_R: begin
                sum    = {1'b0, a} - {1'b0, b};
                alu_lo = sum[N-1:0];
                alu_c  = sum[N];
            end
            OP_MUL_C, OP_MUL_R: begin
                prod   = {{N{1'b0}}, a} * {{N{1'b0}}, b};
                alu_lo = prod[N-1:0];
                alu_hi = prod[2*N-1:N];
            end
            OP_SHL_C, OP_SHL_R: alu_lo = (b >= SHIFT_LIMIT) ? '0 : (a << b);
            OP_SHR_C, OP_SHR_R: alu_lo = (b >= SHIFT_LIMIT) ? '0 : (a >> b);
            default: ;
        endcase
    end

    logic [N-1:0] rem_in, q_in, rem_nx, q_nx;
    logic [N:0]   div_sh, div_diff;

    // One restoring-division step; the first step starts from rem=0, q=A
    always_comb begin
        rem_in   = (cnt == '0) ? '0 : div_rem;
        q_in     = (cnt == '0) ? a : div_q;
        div_sh   = {rem_in, q_in[N-1]};
        div_diff = div_sh - {1'b0, b};
        if (div_sh >= {1'b0, b}) begin
            rem_nx = div_diff[N-1:0];
            q_nx   = {q_in[N-2:0], 1'b1};
        end else begin
            rem_nx = div_sh[N-1:0];
            q_nx   = {q_in[N-2:0], 1'b0};
        end
    end

    // Instruction sequencer; bus controls and status are registered on each transition
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state        <= S_IDLE;
            MemorySelect <= '0;
            MemoryRW     <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            Zero         <= 1'b0;
            Carry        <= 1'b0;
            cnt          <= '0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op   <= op_in;
                        r1   <= p1[M-1:0];
                        r2   <= p2[M-1:0];
                        b    <= p2;
                        Busy <= 1'b1;
                        if (op_in == 4'h0 || op_in == 4'hF) begin
                            state <= S_FINISH;
                            Done  <= 1'b1;
                            Error <= 1'b1;
                        end else if (op_in == OP_LDC) begin
                            state        <= S_WRITE_LO;
                            MemorySelect <= p1[M-1:0];
                            MemoryRW     <= 1'b1;
                            wdata        <= p2;
                            res_lo       <= p2;
                            res_c        <= 1'b0;
                        end else if (op_in == OP_LDR) begin
                            state        <= S_READ_B;
                            MemorySelect <= p2[M-1:0];
                        end else begin
                            state        <= S_READ_A;
                            MemorySelect <= p1[M-1:0];
                        end
                    end
                end
                S_READ_A: begin
                    a   <= MemoryData;
                    cnt <= '0;
                    if (is_reg_op(op)) begin
                        state        <= S_READ_B;
                        MemorySelect <= r2;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_READ_B: begin
                    b   <= MemoryData;
                    cnt <= '0;
                    if (op == OP_LDR) begin
                        state        <= S_WRITE_LO;
                        MemorySelect <= r1;
                        MemoryRW     <= 1'b1;
                        wdata        <= MemoryData;
                        res_lo       <= MemoryData;
                        res_c        <= 1'b0;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_div_op(op)) begin
                        if (cnt == '0 && b == '0) begin
                            state <= S_FINISH;
                            Done  <= 1'b1;
                            Error <= 1'b1;
                        end else begin
                            div_rem <= rem_nx;
                            div_q   <= q_nx;
                            cnt     <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                state        <= S_WRITE_LO;
                                MemorySelect <= r1;
                                MemoryRW     <= 1'b1;
                                wdata        <= q_nx;
                                res_lo       <= q_nx;
                                res_hi       <= rem_nx;
                                res_c        <= 1'b0;
                            end
                        end
                    end else begin
                        state        <= S_WRITE_LO;
                        MemorySelect <= is_mul_op(op) ? ADDR_RA : r1;
                        MemoryRW     <= 1'b1;
                        wdata        <= alu_lo;
                        res_lo       <= alu_lo;
                        res_hi       <= alu_hi;
                        res_c        <= alu_c;
                    end
                end
                S_WRITE_LO: begin
                    if (is_mul_op(op) || is_div_op(op)) begin
                        state        <= S_WRITE_HI;
                        MemorySelect <= ADDR_RD;
                        wdata        <= res_hi;
                    end else begin
                        state    <= S_FINISH;
                        MemoryRW <= 1'b0;
                        Done     <= 1'b1;
                        Zero     <= (res_lo == '0);
                        Carry    <= res_c;
                    end
                end
                S_WRITE_HI: begin
                    state    <= S_FINISH;
                    MemoryRW <= 1'b0;
                    Done     <= 1'b1;
                    Zero     <= (res_lo == '0);
                    Carry    <= res_c;
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    MemoryRW <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
